// File: rtl/char_motion_ctrl_if.sv
// Signal bundle between the board/collision side and the character motion sequencer.
// master drives buttons and contact flags; slave produces the per-frame velocity commands.
interface char_motion_ctrl_if #(
    parameter int VEL_WIDTH    = 8,
    parameter int CHARGE_WIDTH = 5
);
    logic                          frame_tick;
    logic                          left_btn;
    logic                          right_btn;
    logic                          jump_btn;
    logic                          on_ground;
    logic                          hit_wall_l;
    logic                          hit_wall_r;
    logic                          hit_ceiling;
    logic signed [VEL_WIDTH-1:0]   vx;
    logic signed [VEL_WIDTH-1:0]   vy;
    logic [2:0]                    state;
    logic                          facing;
    logic [CHARGE_WIDTH-1:0]       charge;
    logic                          jump_pulse;
    logic                          land_pulse;

    modport master (
        output frame_tick, left_btn, right_btn, jump_btn,
        output on_ground, hit_wall_l, hit_wall_r, hit_ceiling,
        input  vx, vy, state, facing, charge, jump_pulse, land_pulse
    );

    modport slave (
        input  frame_tick, left_btn, right_btn, jump_btn,
        input  on_ground, hit_wall_l, hit_wall_r, hit_ceiling,
        output vx, vy, state, facing, charge, jump_pulse, land_pulse
    );
endinterface

// File: rtl/char_motion_ctrl.sv
// Frame-rate character motion sequencer: synchronized buttons drive a charge-and-release
// jump FSM that emits signed per-frame velocity commands plus takeoff/landing strobes.
module char_motion_ctrl #(
    parameter int VEL_WIDTH    = 8,
    parameter int CHARGE_WIDTH = 5,
    parameter int MAX_CHARGE   = 31,
    parameter int WALK_SPEED   = 2,
    parameter int JUMP_VX      = 3,
    parameter int MIN_JUMP_VY  = 4,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL     = 12,
    parameter int LAND_FRAMES  = 3
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    char_motion_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_CHARGE = 3'd2,
        ST_AIR    = 3'd3,
        ST_LAND   = 3'd4
    } state_t;

    localparam int LCW = (LAND_FRAMES > 1) ? $clog2(LAND_FRAMES) : 1;

    localparam logic signed [VEL_WIDTH-1:0] WALK_V     = VEL_WIDTH'(WALK_SPEED);
    localparam logic signed [VEL_WIDTH-1:0] JUMP_V     = VEL_WIDTH'(JUMP_VX);
    localparam logic signed [VEL_WIDTH-1:0] MIN_JUMP_V = VEL_WIDTH'(MIN_JUMP_VY);
    localparam logic signed [VEL_WIDTH-1:0] GRAV_V     = VEL_WIDTH'(GRAVITY);
    localparam logic signed [VEL_WIDTH-1:0] FALL_V     = VEL_WIDTH'(MAX_FALL);
    localparam logic [CHARGE_WIDTH-1:0]     CHARGE_MAX = CHARGE_WIDTH'(MAX_CHARGE);
    localparam logic [LCW-1:0]              LAND_LAST  = LCW'(LAND_FRAMES - 1);

    logic [1:0] left_sync, right_sync, jump_sync;
    logic       left_s, right_s, jump_s;

    state_t                      state_q, state_d;
    logic signed [VEL_WIDTH-1:0] vx_q, vx_d, vy_q, vy_d;
    logic [CHARGE_WIDTH-1:0]     charge_q, charge_d;
    logic                        facing_q, facing_d;
    logic [LCW-1:0]              land_cnt_q, land_cnt_d;
    logic                        jump_pulse_q, jump_pulse_d;
    logic                        land_pulse_q, land_pulse_d;

    logic                        go_left, go_right, moving;
    logic signed [VEL_WIDTH-1:0] walk_vel, takeoff_vx, takeoff_vy, charge_v;
    logic signed [VEL_WIDTH-1:0] vy_inc, vy_fall;
    logic                        vx_neg, vx_pos, vy_neg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            left_sync  <= '0;
            right_sync <= '0;
            jump_sync  <= '0;
        end else begin
            left_sync  <= {left_sync[0],  bus.left_btn};
            right_sync <= {right_sync[0], bus.right_btn};
            jump_sync  <= {jump_sync[0],  bus.jump_btn};
        end
    end

    assign left_s  = left_sync[1];
    assign right_s = right_sync[1];
    assign jump_s  = jump_sync[1];

    assign go_left  = left_s & ~right_s;
    assign go_right = right_s & ~left_s;
    assign moving   = go_left | go_right;

    assign walk_vel   = go_left ? -WALK_V : (go_right ? WALK_V : '0);
    assign takeoff_vx = go_left ? -JUMP_V : (go_right ? JUMP_V : '0);
    assign charge_v   = VEL_WIDTH'(charge_q);
    assign takeoff_vy = -(MIN_JUMP_V + charge_v);

    // vy never exceeds MAX_FALL, so vy + GRAVITY cannot wrap before the clamp
    assign vy_inc  = vy_q + GRAV_V;
    assign vy_fall = (vy_inc > FALL_V) ? FALL_V : vy_inc;

    assign vx_neg = vx_q[VEL_WIDTH-1];
    assign vx_pos = !vx_q[VEL_WIDTH-1] && (vx_q != '0);
    assign vy_neg = vy_q[VEL_WIDTH-1];

    always_comb begin
        state_d      = state_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        charge_d     = charge_q;
        facing_d     = facing_q;
        land_cnt_d   = land_cnt_q;
        jump_pulse_d = 1'b0;
        land_pulse_d = 1'b0;
        if (bus.frame_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    vx_d = '0;
                    vy_d = '0;
                    if (jump_s) begin
                        state_d  = ST_CHARGE;
                        charge_d = '0;
                    end else if (!bus.on_ground) begin
                        state_d = ST_AIR;
                    end else if (moving) begin
                        state_d = ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (moving) facing_d = go_right;
                    if (jump_s) begin
                        state_d  = ST_CHARGE;
                        vx_d     = '0;
                        charge_d = '0;
                    end else if (!bus.on_ground) begin
                        state_d = ST_AIR;
                        vy_d    = '0;
                    end else if (!moving) begin
                        state_d = ST_IDLE;
                        vx_d    = '0;
                    end else begin
                        vx_d = walk_vel;
                    end
                end
                ST_CHARGE: begin
                    vx_d = '0;
                    if (moving) facing_d = go_right;
                    if (!jump_s) begin
                        state_d      = ST_AIR;
                        vy_d         = takeoff_vy;
                        vx_d         = takeoff_vx;
                        charge_d     = '0;
                        jump_pulse_d = 1'b1;
                    end else if (!bus.on_ground) begin
                        state_d  = ST_AIR;
                        vy_d     = '0;
                        charge_d = '0;
                    end else if (charge_q != CHARGE_MAX) begin
                        charge_d = charge_q + 1'b1;
                    end
                end
                ST_AIR: begin
                    if (bus.on_ground && !vy_neg) begin
                        state_d      = ST_LAND;
                        vx_d         = '0;
                        vy_d         = '0;
                        land_pulse_d = 1'b1;
                        land_cnt_d   = '0;
                    end else begin
                        vy_d = (bus.hit_ceiling && vy_neg) ? GRAV_V : vy_fall;
                        if ((bus.hit_wall_l && vx_neg) || (bus.hit_wall_r && vx_pos))
                            vx_d = -vx_q;
                    end
                end
                ST_LAND: begin
                    if (land_cnt_q == LAND_LAST) begin
                        state_d    = ST_IDLE;
                        land_cnt_d = '0;
                    end else begin
                        land_cnt_d = land_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            vx_q         <= '0;
            vy_q         <= '0;
            charge_q     <= '0;
            facing_q     <= 1'b1;
            land_cnt_q   <= '0;
            jump_pulse_q <= 1'b0;
            land_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            charge_q     <= charge_d;
            facing_q     <= facing_d;
            land_cnt_q   <= land_cnt_d;
            jump_pulse_q <= jump_pulse_d;
            land_pulse_q <= land_pulse_d;
        end
    end

    assign bus.vx         = vx_q;
    assign bus.vy         = vy_q;
    assign bus.state      = state_q;
    assign bus.facing     = facing_q;
    assign bus.charge     = charge_q;
    assign bus.jump_pulse = jump_pulse_q;
    assign bus.land_pulse = land_pulse_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed plus randomized bench for char_motion_ctrl, checked against an integer
// behavioural model of the motion rules.
module tb_char_motion_ctrl;

    localparam int VW    = 8;
    localparam int CW    = 5;
    localparam int WALK  = 2;
    localparam int JVX   = 3;
    localparam int MINVY = 4;
    localparam int G     = 1;
    localparam int MAXF  = 12;
    localparam int MAXC  = 31;
    localparam int LANDN = 3;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    char_motion_ctrl_if #(.VEL_WIDTH(VW), .CHARGE_WIDTH(CW)) bus ();

    char_motion_ctrl #(
        .VEL_WIDTH(VW), .CHARGE_WIDTH(CW), .MAX_CHARGE(MAXC), .WALK_SPEED(WALK),
        .JUMP_VX(JVX), .MIN_JUMP_VY(MINVY), .GRAVITY(G), .MAX_FALL(MAXF),
        .LAND_FRAMES(LANDN)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model state (state codes: 0 idle, 1 walk, 2 charge, 3 air, 4 land)
    int m_st, m_vx, m_vy, m_ch, m_fc, m_cnt, m_jp, m_lp;
    bit ml, mr, mj, mg, mwl, mwr, mc;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_vx = 0; m_vy = 0; m_ch = 0; m_fc = 1; m_cnt = 0; m_jp = 0; m_lp = 0;
    endtask

    task automatic model_step();
        int dir;
        int nvy;
        dir  = (ml && !mr) ? -1 : ((mr && !ml) ? 1 : 0);
        m_jp = 0;
        m_lp = 0;
        case (m_st)
            0: begin
                m_vx = 0; m_vy = 0;
                if (mj) begin m_st = 2; m_ch = 0; end
                else if (!mg) m_st = 3;
                else if (dir != 0) m_st = 1;
            end
            1: begin
                if (dir != 0) m_fc = (dir > 0) ? 1 : 0;
                if (mj) begin m_st = 2; m_vx = 0; m_ch = 0; end
                else if (!mg) begin m_st = 3; m_vy = 0; end
                else if (dir == 0) begin m_st = 0; m_vx = 0; end
                else m_vx = dir * WALK;
            end
            2: begin
                m_vx = 0;
                if (dir != 0) m_fc = (dir > 0) ? 1 : 0;
                if (!mj) begin
                    m_st = 3; m_vy = -(MINVY + m_ch); m_vx = dir * JVX; m_ch = 0; m_jp = 1;
                end else if (!mg) begin
                    m_st = 3; m_vy = 0; m_ch = 0;
                end else if (m_ch < MAXC) m_ch++;
            end
            3: begin
                if (mg && m_vy >= 0) begin
                    m_st = 4; m_vx = 0; m_vy = 0; m_lp = 1; m_cnt = 0;
                end else begin
                    nvy = m_vy + G;
                    if (nvy > MAXF) nvy = MAXF;
                    if (mc && m_vy < 0) nvy = G;
                    if ((mwl && m_vx < 0) || (mwr && m_vx > 0)) m_vx = -m_vx;
                    m_vy = nvy;
                end
            end
            4: begin
                m_cnt++;
                if (m_cnt == LANDN) begin m_st = 0; m_cnt = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  int'(bus.state),      m_st);
        chk({tag, ".vx"},     int'(bus.vx),         m_vx);
        chk({tag, ".vy"},     int'(bus.vy),         m_vy);
        chk({tag, ".facing"}, int'(bus.facing),     m_fc);
        chk({tag, ".charge"}, int'(bus.charge),     m_ch);
        chk({tag, ".jp"},     int'(bus.jump_pulse), m_jp);
        chk({tag, ".lp"},     int'(bus.land_pulse), m_lp);
    endtask

    // drive inputs, let the synchronizers settle without any tick, confirm outputs held
    task automatic set_in(input bit l, input bit r, input bit j, input bit g,
                          input bit wl, input bit wr, input bit c);
        @(negedge sys_clk);
        bus.left_btn = l; bus.right_btn = r; bus.jump_btn = j; bus.on_ground = g;
        bus.hit_wall_l = wl; bus.hit_wall_r = wr; bus.hit_ceiling = c;
        repeat (3) @(negedge sys_clk);
        ml = l; mr = r; mj = j; mg = g; mwl = wl; mwr = wr; mc = c;
        m_jp = 0; m_lp = 0;
        check_all("hold");
    endtask

    task automatic tick_n(input string tag, input int n);
        @(negedge sys_clk);
        bus.frame_tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            if (i == n - 1) bus.frame_tick = 1'b0;
            model_step();
            check_all(tag);
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0; bus.left_btn = 1'b0; bus.right_btn = 1'b0; bus.jump_btn = 1'b0;
        bus.on_ground = 1'b0; bus.hit_wall_l = 1'b0; bus.hit_wall_r = 1'b0; bus.hit_ceiling = 1'b0;
        {ml, mr, mj, mg, mwl, mwr, mc} = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // button latency: two sync flops, effect on the third back-to-back tick
        set_in(0, 0, 0, 1, 0, 0, 0);
        @(negedge sys_clk);
        bus.right_btn  = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge sys_clk); model_step(); check_all("lat1");
        @(negedge sys_clk); model_step(); check_all("lat2");
        mr = 1'b1;
        @(negedge sys_clk); bus.frame_tick = 1'b0; model_step(); check_all("lat3");
        chk("lat_walk", int'(bus.state), 1);

        // walk right, then both buttons stop
        tick_n("walk", 2);
        chk("walk_vx", int'(bus.vx), 2);
        chk("walk_facing", int'(bus.facing), 1);
        set_in(1, 1, 0, 1, 0, 0, 0);
        tick_n("both", 1);
        chk("both_state", int'(bus.state), 0);
        chk("both_vx", int'(bus.vx), 0);

        // walk left flips facing
        set_in(1, 0, 0, 1, 0, 0, 0);
        tick_n("walk_l", 2);
        chk("walk_l_vx", int'(bus.vx), -2);
        chk("walk_l_facing", int'(bus.facing), 0);
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick_n("stop", 1);

        // charge 10 frames with right held, release
        set_in(0, 1, 1, 1, 0, 0, 0);
        tick_n("chg_in", 1);
        tick_n("chg", 10);
        chk("chg10", int'(bus.charge), 10);
        set_in(0, 1, 0, 1, 0, 0, 0);
        tick_n("rel10", 1);
        chk("rel10_jp", int'(bus.jump_pulse), 1);
        chk("rel10_state", int'(bus.state), 3);
        chk("rel10_vx", int'(bus.vx), 3);
        chk("rel10_vy", int'(bus.vy), -14);
        @(negedge sys_clk);
        chk("jp_one_cycle", int'(bus.jump_pulse), 0);

        // wall bounce, then wall flag against an already-reversed vx
        set_in(0, 0, 0, 0, 0, 1, 0);
        tick_n("wall_r", 1);
        chk("wall_r_vx", int'(bus.vx), -3);
        tick_n("wall_r2", 1);
        chk("wall_r2_vx", int'(bus.vx), -3);
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20 && m_vy != -8; k++) tick_n("rise", 1);
        chk("rise_vy", int'(bus.vy), -8);
        set_in(0, 0, 0, 0, 0, 0, 1);
        tick_n("ceil", 1);
        chk("ceil_vy", int'(bus.vy), 1);

        // landing with walls asserted; jump during LAND ignored
        set_in(0, 0, 0, 1, 1, 1, 0);
        tick_n("land", 1);
        chk("land_state", int'(bus.state), 4);
        chk("land_lp", int'(bus.land_pulse), 1);
        chk("land_vx", int'(bus.vx), 0);
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick_n("landing", 2);
        chk("land_hold", int'(bus.state), 4);
        tick_n("landing", 1);
        chk("land_done", int'(bus.state), 0);

        // charge saturation
        tick_n("sat_in", 1);
        tick_n("sat", 40);
        chk("sat_charge", int'(bus.charge), 31);
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick_n("sat_rel", 1);
        chk("sat_vy", int'(bus.vy), -35);
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 64 && m_vy <= 0; k++) tick_n("fall", 1);
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick_n("land2", 1);
        tick_n("land2w", LANDN);
        chk("land2_idle", int'(bus.state), 0);

        // zero-charge jump then gravity profile
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick_n("z_in", 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick_n("z_rel", 1);
        chk("z_vy", int'(bus.vy), -4);
        for (int k = 1; k <= 20; k++) begin
            tick_n("grav", 1);
            chk("grav_vy", int'(bus.vy), (-4 + k * G > MAXF) ? MAXF : -4 + k * G);
        end

        // jump to vy=-20 then asynchronous reset mid-air
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick_n("land3", 1 + LANDN);
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick_n("c16", 17);
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick_n("c16_rel", 1);
        chk("c16_vy", int'(bus.vy), -20);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 model_reset();
        check_all("rst_air");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // randomized frames, including back-to-back ticks
        for (int it = 0; it < 250; it++) begin
            bit l, r, j, g, wl, wr, c;
            l  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            j  = ($urandom_range(0, 2) != 0);
            g  = ($urandom_range(0, 3) != 0);
            wl = ($urandom_range(0, 3) == 0);
            wr = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 3) == 0);
            set_in(l, r, j, g, wl, wr, c);
            tick_n("rand", ($urandom_range(0, 3) == 0) ? 2 : 1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge sys_clk);
                chk("rand_jp_clr", int'(bus.jump_pulse), 0);
                chk("rand_lp_clr", int'(bus.land_pulse), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
